// File: rtl/rv32i_pkg.sv
// Shared types for the multicycle RV32I controller: FSM states, opcodes and
// datapath select encodings.
package rv32i_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_WAIT      = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_MEM_WAIT  = 3'd5,
    S_WRITEBACK = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_sel_t;
  typedef enum logic [1:0] {OPC_ADD = 2'd0, OPC_FUNCT = 2'd1, OPC_BRANCH = 2'd2} alu_op_class_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} wb_sel_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps opcode[6:0] to legality, datapath
// selects and instruction-class flags.
module ctrl_decode
  import rv32i_pkg::*;
(
  input  logic [6:0]    opcode_i,
  output logic          legal_o,
  output alu_a_sel_t    alu_a_sel_o,
  output logic          alu_b_sel_o,
  output alu_op_class_t alu_op_class_o,
  output wb_sel_t       wb_sel_o,
  output logic          is_load_o,
  output logic          is_store_o,
  output logic          is_branch_o,
  output logic          is_jump_o
);

  always_comb begin
    legal_o        = 1'b1;
    alu_a_sel_o    = A_RS1;
    alu_b_sel_o    = 1'b0;
    alu_op_class_o = OPC_ADD;
    wb_sel_o       = WB_ALU;
    is_load_o      = 1'b0;
    is_store_o     = 1'b0;
    is_branch_o    = 1'b0;
    is_jump_o      = 1'b0;
    case (opcode_i)
      OP_R:      alu_op_class_o = OPC_FUNCT;
      OP_IALU: begin
        alu_b_sel_o    = 1'b1;
        alu_op_class_o = OPC_FUNCT;
      end
      OP_LOAD: begin
        alu_b_sel_o = 1'b1;
        wb_sel_o    = WB_MEM;
        is_load_o   = 1'b1;
      end
      OP_STORE: begin
        alu_b_sel_o = 1'b1;
        is_store_o  = 1'b1;
      end
      OP_BRANCH: begin
        alu_op_class_o = OPC_BRANCH;
        is_branch_o    = 1'b1;
      end
      OP_JAL: begin
        wb_sel_o  = WB_PC4;
        is_jump_o = 1'b1;
      end
      OP_JALR: begin
        alu_b_sel_o = 1'b1;
        wb_sel_o    = WB_PC4;
        is_jump_o   = 1'b1;
      end
      OP_LUI:    wb_sel_o = WB_IMM;
      OP_AUIPC: begin
        alu_a_sel_o = A_PC;
        alu_b_sel_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer owning PC and IR. Optional macro
// RETIRE_COUNTER_EN adds a 32-bit retired-instruction counter output.
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data_out,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  input  logic        branch_taken,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op_class,
  output logic [31:0] dmem_address,
  output logic        dmem_wren,
  output logic        regfile_wren,
  output logic [1:0]  wb_sel,
  output logic        trap
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d, npc_q, instr_q, dmem_addr_q;

  logic          dec_legal, dec_b_sel, dec_load, dec_store, dec_branch, dec_jump;
  alu_a_sel_t    dec_a_sel;
  alu_op_class_t dec_class;
  wb_sel_t       dec_wb;

  ctrl_decode u_decode (
    .opcode_i       (instr_q[6:0]),
    .legal_o        (dec_legal),
    .alu_a_sel_o    (dec_a_sel),
    .alu_b_sel_o    (dec_b_sel),
    .alu_op_class_o (dec_class),
    .wb_sel_o       (dec_wb),
    .is_load_o      (dec_load),
    .is_store_o     (dec_store),
    .is_branch_o    (dec_branch),
    .is_jump_o      (dec_jump)
  );

  logic [31:0] target;
  logic        redirect, misaligned;

  // Next PC is resolved in EXECUTE while imm/alu_out/branch_taken are valid.
  always_comb begin
    target = pc_q + 32'd4;
    if (instr_q[6:0] == OP_JALR)
      target = {alu_out[31:1], 1'b0};
    else if (dec_jump || (dec_branch && branch_taken))
      target = pc_q + imm;
  end

  assign redirect   = dec_jump || (dec_branch && branch_taken);
  assign misaligned = redirect && target[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_WAIT;
      S_WAIT:      if (cnt_q == LAT_LAST) state_d = S_DECODE;
      S_DECODE:    state_d = dec_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (misaligned)                  state_d = S_TRAP;
        else if (dec_load || dec_store)  state_d = S_MEM;
        else if (dec_branch)             state_d = S_FETCH;
        else                             state_d = S_WRITEBACK;
      end
      S_MEM:       state_d = dec_store ? S_FETCH : S_MEM_WAIT;
      S_MEM_WAIT:  if (cnt_q == LAT_LAST) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_TRAP;
    endcase
  end

  always_comb begin
    cnt_d = 3'd0;
    if ((state_q == S_WAIT || state_q == S_MEM_WAIT) && state_d == state_q)
      cnt_d = cnt_q + 3'd1;
  end

  always_comb begin
    pc_d = pc_q;
    if (state_d == S_FETCH) begin
      if (state_q == S_EXECUTE)
        pc_d = target;
      else if (state_q == S_MEM || state_q == S_WRITEBACK)
        pc_d = npc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= 3'd0;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC;
      instr_q     <= 32'd0;
      dmem_addr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      if (state_q == S_WAIT && state_d == S_DECODE)
        instr_q <= imem_data_out;
      if (state_q == S_EXECUTE) begin
        npc_q       <= target;
        dmem_addr_q <= alu_out;
      end
    end
  end

`ifdef RETIRE_COUNTER_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      instret_q <= 32'd0;
    else if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

  logic sel_vld;
  assign sel_vld = (state_q == S_EXECUTE) || (state_q == S_MEM) ||
                   (state_q == S_MEM_WAIT) || (state_q == S_WRITEBACK);

  assign imem_address = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign dmem_address = dmem_addr_q;
  assign alu_a_sel    = sel_vld ? dec_a_sel : A_RS1;
  assign alu_b_sel    = sel_vld & dec_b_sel;
  assign alu_op_class = sel_vld ? dec_class : OPC_ADD;
  assign wb_sel       = sel_vld ? dec_wb : WB_ALU;
  assign dmem_wren    = (state_q == S_MEM) && dec_store;
  assign regfile_wren = (state_q == S_WRITEBACK);
  assign trap         = (state_q == S_TRAP);

endmodule
